// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: FSM encoding and counter sizing.
package bcd_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Iteration counter must hold BIN_W itself, hence BIN_W+1 states.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit exceeds 4. Purely combinational.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_serial_conv.sv
// Serial double-dabble binary-to-BCD converter with leading-zero mask and overflow flag.
// Latency BIN_W cycles from accepted start to done; start is ignored while busy, no other backpressure.
module bcd_serial_conv
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int CW = cnt_width(BIN_W);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    state_t              state;
    logic [BIN_W-1:0]    sr;
    logic [4*DIGITS-1:0] work;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] next_work;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;
    logic                shift_out;
    logic [DIGITS-1:0]   next_blank;
    logic                zero_run;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (work[4*i +: 4]),
            .adj   (adj[4*i +: 4])
        );
    end

    // The bit leaving the top digit is lost from bcd but recorded as overflow.
    assign next_work = {adj[4*DIGITS-2:0], sr[BIN_W-1]};
    assign shift_out = adj[4*DIGITS-1];

    always_comb begin
        next_blank = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (next_work[4*i +: 4] == 4'd0);
            next_blank[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
            cnt      <= '0;
            sr       <= '0;
            work     <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr       <= number;
                        work     <= '0;
                        cnt      <= CW'(BIN_W);
                        ovf_pend <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work     <= next_work;
                    sr       <= sr << 1;
                    cnt      <= cnt - CW'(1);
                    ovf_pend <= ovf_pend | shift_out;
                    if (cnt == CW'(1)) begin
                        bcd      <= next_work;
                        blank    <= next_blank;
                        overflow <= ovf_pend | shift_out;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bcd_serial_conv.md
BCD_SERIAL_CONV -- requirements
Module: bcd_serial_conv

Interface
REQ-001 Parameter BIN_W, default 32, binary input width (>=1).
REQ-002 Parameter DIGITS, default 8, number of BCD output digits (>=1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a conversion of number; sampled only in IDLE.
REQ-006 number  input  BIN_W  unsigned binary value, captured on the accepted start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse; bcd/blank/overflow valid and updated.
REQ-009 bcd  output  4*DIGITS  packed digits; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-010 blank  output  DIGITS  leading-zero mask; bit i high means digit i is a suppressible leading zero.
REQ-011 overflow  output  1  high when the last converted number >= 10^DIGITS.

Function
REQ-012 Two-state FSM: IDLE and SHIFT.
REQ-013 IDLE with start=1 at edge k: capture number into the shift register, clear the working BCD register, load the iteration counter with BIN_W, and enter SHIFT.
REQ-014 busy is high in every cycle after edge k through edge k+BIN_W.
REQ-015 Each SHIFT cycle performs one double-dabble iteration:
  - add 3 to every working digit > 4;
  - shift {working BCD, binary MSB} left by one;
  - decrement the counter.
REQ-016 A 1 shifted out of the top working digit sets a sticky overflow-pending flag, cleared on start.
REQ-017 At edge k+BIN_W (final iteration), register the result into bcd, blank and overflow, then return to IDLE.
  - done=1 for exactly the one cycle following that edge.
  - Start-to-done latency is BIN_W cycles.
REQ-018 On overflow, bcd holds number mod 10^DIGITS (low DIGITS digits of the exact decimal value) and overflow=1.
REQ-019 blank[0] is always 0; blank[i] for i>0 is 1 iff digit i and all higher digits are zero.
REQ-020 bcd, blank and overflow hold their values between conversions and change only at REQ-017 or on reset.
REQ-021 start while busy is ignored; number changes while busy have no effect.
REQ-022 start in the done cycle (state IDLE) is accepted, giving back-to-back conversions with no idle cycle.
REQ-023 All digit arithmetic is 4-bit, unsigned, with no carry between digits except via the shift.

Reset
REQ-024 rst=1 at any edge forces IDLE and sets: busy=0, done=0, bcd=0, overflow=0, counter=0, blank = all ones except bit 0.
REQ-025 rst during SHIFT aborts the conversion; no done pulse is produced for it.
REQ-026 start is ignored in any cycle where rst=1.

Structure
REQ-027 Shared package bcd_pkg holds the FSM state encoding and the counter width constant (clog2(BIN_W+1)).
REQ-028 One sub-module, bcd_digit_adj: a combinational 4-bit "add 3 if >4" cell, instantiated DIGITS times via generate.

Verification
REQ-029 Default params, number=0, start pulse:
  - done exactly 32 cycles after the start edge;
  - bcd=0x00000000, blank=8'hFE, overflow=0.
REQ-030 Default params, number=12345678 -> bcd=0x12345678, blank=0, overflow=0; number=99999999 -> bcd=0x99999999, overflow=0.
REQ-031 Default params:
  - number=100000000 -> bcd=0x00000000, overflow=1;
  - number=0xFFFFFFFF -> bcd=0x94967295, overflow=1.
REQ-032 Start with 42, then start with 7 at cycle 5 (ignored) -> bcd=0x00000042; then start with 305 in the done cycle -> second done exactly 32 cycles later with bcd=0x00000305, blank=8'hF8.
REQ-033 rst asserted at cycle 10 of a conversion:
  - busy=0 on the next cycle, no done, bcd=0, blank=8'hFE;
  - a fresh start afterwards converts correctly.
REQ-034 BIN_W=8, DIGITS=3, number=255 -> done after 8 cycles, bcd=12'h255, overflow=0; DIGITS=2, number=255 -> bcd=8'h55, overflow=1.
